// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
//
// Hazard and pipeline-control unit for a classic five-stage in-order core.
// Decides every cycle whether the front of the pipe holds, whether stages
// are killed (flush / bubble), and which operand source the EX stage uses.
//
// Three sources of control, in priority order:
//   1. freeze   - the MEM stage is waiting on data memory. Everything from
//                 PC through EX/MEM holds and a bubble goes into MEM/WB.
//                 A wait that exceeds TMO cycles locks the block in ERR,
//                 which freezes permanently until reset.
//   2. redirect - a taken branch in EX flushes IF/ID and bubbles ID/EX.
//   3. load-use - the instruction in ID needs a load result still in EX.
//                 PC and IF/ID hold for one cycle and ID/EX gets a bubble.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   id_rs1, id_rs2               ID-stage source register numbers
//   id_use_rs1, id_use_rs2       ID-stage source actually read
//   ex_rs1, ex_rs2, ex_rd        EX-stage register numbers
//   ex_mem_read                  EX stage holds a load
//   ex_branch_taken              EX stage requests a redirect
//   mem_rd, mem_reg_write        EX/MEM destination and write enable
//   wb_rd, wb_reg_write          MEM/WB destination and write enable
//   dmem_req, dmem_ready         MEM stage access pending / completes now
//   stall_pc .. stall_ex_mem     hold controls
//   flush_if_id, bubble_id_ex,
//   bubble_mem_wb                kill controls
//   fwd_a, fwd_b                 operand select: 00 regfile, 01 EX/MEM,
//                                10 MEM/WB
//   err_tmo                      sticky memory-timeout flag
//   stall_cnt, flush_cnt         free-running wrap-around event counters
//   state                        FSM state (00 RUN, 01 MEM_WAIT, 10 ERR)
// ----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 32,
    parameter int TMO   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_mem_wb,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             err_tmo,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    // The wait counter holds the number of MEM_WAIT cycles already spent.
    // When it is at TMO-1 and memory is still not ready, this cycle makes
    // the count reach TMO and the block gives up.
    localparam logic [15:0] WAIT_LAST = 16'(TMO - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] wait_cnt_reg;
    logic [15:0] wait_cnt_next;
    logic        err_tmo_reg;
    logic        err_tmo_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic        freeze;
    logic        load_use;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
            err_tmo_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            err_tmo_reg  <= err_tmo_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and freeze decision
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        err_tmo_next  = err_tmo_reg;
        freeze        = 1'b0;
        case (state_reg)
            ST_RUN: begin
                // The first missed cycle already freezes; the FSM only
                // catches up on the following edge.
                if (dmem_req && !dmem_ready) begin
                    freeze        = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            ST_MEM_WAIT: begin
                wait_cnt_next = wait_cnt_reg + 16'd1;
                if (dmem_ready) begin
                    // Completion cycle: the pipe advances right now.
                    state_next = ST_RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_next   = ST_ERR;
                        err_tmo_next = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load-use detection. x0 never carries a real dependency.
    // ------------------------------------------------------------------
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // ------------------------------------------------------------------
    // Hold / kill outputs. A redirect seen during a freeze is not lost:
    // the branch stays in the held EX stage, so it is acted on in the
    // first cycle the freeze drops, whichever FSM state that is in.
    // ------------------------------------------------------------------
    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        stall_ex_mem  = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_mem_wb = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_ex   = 1'b1;
                stall_ex_mem  = 1'b1;
                bubble_mem_wb = 1'b1;
            end else if (ex_branch_taken) begin
                // The wrong-path instruction in ID is killed, so any
                // load-use hazard it might have is irrelevant.
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (load_use) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding, one identical selector per EX source operand.
    // The younger producer (EX/MEM) wins over MEM/WB.
    // ------------------------------------------------------------------
    logic [4:0] ex_src  [2];
    logic [1:0] fwd_sel [2];

    assign ex_src[0] = ex_rs1;
    assign ex_src[1] = ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_src[gi])) ? 2'b01 :
                (wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == ex_src[gi])) ? 2'b10 :
                                                                                  2'b00;
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    // ------------------------------------------------------------------
    // Performance counters, wrapping naturally at 2^CNT_W.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, stall_pc};
            flush_cnt_reg <= flush_cnt_reg + {{(CNT_W-1){1'b0}}, flush_if_id};
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
    assign err_tmo   = err_tmo_reg;
    assign state     = state_reg;

endmodule
